// File: rtl/data_mem_resp.sv
// data_mem_resp
//   Responder end of the core's load/store interface. Accepts one request at a
//   time, waits WAIT_CYCLES cycles, then performs a byte, half or word access
//   into a little-endian, byte-addressed RAM and returns the result.
//
//   The RAM is split into four byte lanes (data_mem_lane). A word index selects
//   the row, and a per-lane write enable selects the bytes to write.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   req_valid/ready     request handshake; ready only in IDLE
//   req_we              1 = store, 0 = load
//   req_addr            byte address (A_WIDTH)
//   req_wdata           store data, low bytes used per size
//   req_size            00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned        zero-extend (1) / sign-extend (0) sub-word loads
//   resp_valid/ready    response handshake; valid only in RESP
//   resp_rdata          load result, 0 for stores and errors
//   resp_err            misaligned, illegal size or out of range

module data_mem_lane #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata
);
  logic [7:0] mem [DEPTH];

  // No reset: RAM contents survive rst.
  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;

  assign rdata = mem[idx];
endmodule

module data_mem_resp #(
  parameter int A_WIDTH     = 32,
  parameter int D_WIDTH     = 32,
  parameter int MEM_BYTES   = 4096,
  parameter int WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [A_WIDTH-1:0] req_addr,
  input  logic [D_WIDTH-1:0] req_wdata,
  input  logic [1:0]         req_size,
  input  logic               req_unsigned,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [D_WIDTH-1:0] resp_rdata,
  output logic               resp_err
);
  localparam int NUM_LANES = D_WIDTH / 8;
  localparam int DEPTH     = MEM_BYTES / NUM_LANES;
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so the limit itself is representable for any A_WIDTH.
  localparam logic [A_WIDTH:0] MEM_LIMIT = (A_WIDTH+1)'(MEM_BYTES);

  typedef struct packed {
    logic               we;
    logic [A_WIDTH-1:0] addr;
    logic [D_WIDTH-1:0] wdata;
    logic [1:0]         size;
    logic               uns;
  } mem_req_t;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t   state, next_state;
  mem_req_t q;
  logic [3:0] wait_cnt;
  logic       accept, q_err, commit;

  logic [NUM_LANES-1:0]      lane_mask;
  logic [NUM_LANES-1:0][7:0] lane_wdata;
  logic [NUM_LANES-1:0][7:0] lane_rdata;
  logic [4:0]                shift;
  logic [D_WIDTH-1:0]        rd_sh;
  logic [D_WIDTH-1:0]        load_ext;

  assign req_ready  = (state == IDLE) && !rst;
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;

  // Error check on the latched request; resolved in the first ACCESS cycle so
  // an error response appears one edge after acceptance.
  always_comb begin
    q_err = 1'b0;
    unique case (q.size)
      2'b00: q_err = 1'b0;
      2'b01: q_err = q.addr[0];
      2'b10: q_err = |q.addr[1:0];
      default: q_err = 1'b1;
    endcase
    if ({1'b0, q.addr} >= MEM_LIMIT) q_err = 1'b1;
  end

  assign commit = (state == ACCESS) && !q_err && (wait_cnt == 4'd0);

  // ---- FSM ----
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= next_state;

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = ACCESS;
      ACCESS:  if (q_err || wait_cnt == 4'd0) next_state = RESP;
      RESP:    if (resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // ---- request latch, wait counter, response registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q          <= '0;
      wait_cnt   <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        q.we     <= req_we;
        q.addr   <= req_addr;
        q.wdata  <= req_wdata;
        q.size   <= req_size;
        q.uns    <= req_unsigned;
        wait_cnt <= 4'(WAIT_CYCLES);
      end else if (state == ACCESS && !q_err && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end

      if (state == ACCESS && q_err) begin
        resp_err   <= 1'b1;
        resp_rdata <= '0;
      end else if (commit) begin
        resp_err   <= 1'b0;
        resp_rdata <= q.we ? '0 : load_ext;
      end else if (state == RESP && resp_ready) begin
        resp_err   <= 1'b0;
        resp_rdata <= '0;
      end
    end
  end

  // ---- byte-lane steering ----
  // Legal accesses are naturally aligned, so they never cross a row; the
  // store data is shifted up to its lane and the read row is shifted down.
  assign shift = {q.addr[1:0], 3'b000};

  always_comb begin
    lane_mask = '0;
    unique case (q.size)
      2'b00:   lane_mask = 4'b0001 << q.addr[1:0];
      2'b01:   lane_mask = 4'b0011 << q.addr[1:0];
      default: lane_mask = 4'b1111;
    endcase
  end

  assign lane_wdata = q.wdata << shift;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    data_mem_lane #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_lane (
      .clk   (clk),
      .we    (commit && q.we && lane_mask[l]),
      .idx   (q.addr[IDX_W+1:2]),
      .wdata (lane_wdata[l]),
      .rdata (lane_rdata[l])
    );
  end

  assign rd_sh = lane_rdata >> shift;

  always_comb begin
    load_ext = rd_sh;
    unique case (q.size)
      2'b00: load_ext = q.uns ? {{(D_WIDTH-8){1'b0}}, rd_sh[7:0]}
                              : {{(D_WIDTH-8){rd_sh[7]}}, rd_sh[7:0]};
      2'b01: load_ext = q.uns ? {{(D_WIDTH-16){1'b0}}, rd_sh[15:0]}
                              : {{(D_WIDTH-16){rd_sh[15]}}, rd_sh[15:0]};
      default: load_ext = rd_sh;
    endcase
  end
endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp. Three instances (WAIT_CYCLES 1, 3, 0) share the
// request fields; `sel` routes req_valid to one of them. A byte-array model
// per instance supplies expected load data and error flags.
module tb_data_mem_resp;
  localparam int MEMB = 4096;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int          sel;
  logic        req_valid, req_we, req_unsigned, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic [2:0]  rv, rdy, vld, err;
  logic [2:0][31:0] rdata;

  assign rv = req_valid ? (3'b001 << sel) : 3'b000;

  data_mem_resp #(.MEM_BYTES(MEMB), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rdy[0]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .resp_valid(vld[0]), .resp_ready(resp_ready),
    .resp_rdata(rdata[0]), .resp_err(err[0]));
  data_mem_resp #(.MEM_BYTES(MEMB), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rdy[1]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .resp_valid(vld[1]), .resp_ready(resp_ready),
    .resp_rdata(rdata[1]), .resp_err(err[1]));
  data_mem_resp #(.MEM_BYTES(MEMB), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .req_valid(rv[2]), .req_ready(rdy[2]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .resp_valid(vld[2]), .resp_ready(resp_ready),
    .resp_rdata(rdata[2]), .resp_err(err[2]));

  int checks = 0;
  int errors = 0;
  logic [7:0] mdl [3][MEMB];

  function automatic int wait_of(input int inst);
    case (inst)
      0: return 1;
      1: return 3;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Reference: bytes in an array, sizes/extension from plain arithmetic.
  function automatic void model_access(input int inst, input bit we, input logic [31:0] addr,
                                       input logic [31:0] wd, input logic [1:0] sz, input bit uns,
                                       output logic [31:0] rd, output bit e);
    int n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    longint unsigned v = 0;
    e  = (sz == 2'b11) || ((addr % n) != 0) || (addr >= 32'(MEMB));
    rd = 32'h0;
    if (e) return;
    for (int i = 0; i < n; i++) begin
      int idx = int'(addr[11:0]) + i;
      if (we) mdl[inst][idx] = wd[8*i +: 8];
      else    v = v | (longint'(mdl[inst][idx]) << (8*i));
    end
    if (!we) begin
      if (!uns && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
      rd = v[31:0];
    end
  endfunction

  task automatic start_req(input int inst, input bit we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [1:0] sz, input bit uns,
                           output bit ok);
    int t = 0;
    @(negedge clk);
    sel = inst; req_we = we; req_addr = addr; req_wdata = wd;
    req_size = sz; req_unsigned = uns; req_valid = 1'b1; resp_ready = 1'b0;
    while (!rdy[inst] && t < 50) begin @(negedge clk); t++; end
    ok = rdy[inst];
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
    end else begin
      @(posedge clk); #1 req_valid = 1'b0;
    end
  endtask

  task automatic do_req(input int inst, input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [1:0] sz, input bit uns,
                        input int hold, input logic [31:0] exp_rd, input bit exp_err,
                        input string nm);
    bit ok;
    int lat = 0;
    int exp_lat = exp_err ? 1 : wait_of(inst) + 1;
    start_req(inst, we, addr, wd, sz, uns, ok);
    if (!ok) return;
    do begin @(posedge clk); #1; lat++; end while (!vld[inst] && lat < 50);
    chk($sformatf("%s_lat", nm), 32'(lat), 32'(exp_lat));
    chk($sformatf("%s_rdata", nm), rdata[inst], exp_rd);
    chk($sformatf("%s_err", nm), 32'(err[inst]), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk($sformatf("%s_hold_vld", nm), 32'(vld[inst]), 32'd1);
      chk($sformatf("%s_hold_rdata", nm), rdata[inst], exp_rd);
      chk($sformatf("%s_hold_err", nm), 32'(err[inst]), 32'(exp_err));
      chk($sformatf("%s_hold_rdy", nm), 32'(rdy[inst]), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
    chk($sformatf("%s_done_vld", nm), 32'(vld[inst]), 32'd0);
    chk($sformatf("%s_done_rdy", nm), 32'(rdy[inst]), 32'd1);
  endtask

  task automatic model_req(input int inst, input bit we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [1:0] sz, input bit uns,
                           input int hold, input string nm);
    logic [31:0] rd;
    bit e;
    model_access(inst, we, addr, wd, sz, uns, rd, e);
    do_req(inst, we, addr, wd, sz, uns, hold, rd, e, nm);
  endtask

  typedef struct {
    int          inst;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  sz;
    bit          uns;
    int          hold;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    logic [31:0] dummy_rd, old_val, b_exp[4];
    logic [31:0] b_addr[4];
    bit dummy_e, ok;
    int acc_cyc[4];
    int na, nv;

    tbl.push_back('{0, 1'b1, 32'h10,  32'hDEADBEEF, 2'd2, 1'b0, 0, 32'h0,        1'b0});
    tbl.push_back('{0, 1'b0, 32'h10,  32'h0,        2'd2, 1'b0, 0, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{0, 1'b0, 32'h10,  32'h0,        2'd0, 1'b0, 0, 32'hFFFFFFEF, 1'b0});
    tbl.push_back('{0, 1'b0, 32'h10,  32'h0,        2'd0, 1'b1, 0, 32'h000000EF, 1'b0});
    tbl.push_back('{0, 1'b0, 32'h12,  32'h0,        2'd1, 1'b0, 0, 32'hFFFFDEAD, 1'b0});
    tbl.push_back('{0, 1'b0, 32'h12,  32'h0,        2'd1, 1'b1, 0, 32'h0000DEAD, 1'b0});
    tbl.push_back('{0, 1'b1, 32'h11,  32'hAAAAAA55, 2'd0, 1'b0, 0, 32'h0,        1'b0});
    tbl.push_back('{0, 1'b0, 32'h10,  32'h0,        2'd2, 1'b0, 0, 32'hDEAD55EF, 1'b0});
    tbl.push_back('{0, 1'b0, 32'h10,  32'h0,        2'd1, 1'b1, 0, 32'h000055EF, 1'b0});
    tbl.push_back('{0, 1'b0, 32'h13,  32'h0,        2'd0, 1'b0, 0, 32'hFFFFFFDE, 1'b0});
    tbl.push_back('{0, 1'b0, 32'h11,  32'h0,        2'd1, 1'b0, 0, 32'h0,        1'b1});
    tbl.push_back('{0, 1'b0, 32'h12,  32'h0,        2'd2, 1'b0, 0, 32'h0,        1'b1});
    tbl.push_back('{0, 1'b0, 32'h0,   32'h0,        2'd3, 1'b0, 0, 32'h0,        1'b1});
    tbl.push_back('{0, 1'b0, 32'd4096, 32'h0,       2'd2, 1'b0, 0, 32'h0,        1'b1});
    tbl.push_back('{0, 1'b1, 32'h12,  32'hFFFFFFFF, 2'd2, 1'b0, 0, 32'h0,        1'b1});
    tbl.push_back('{0, 1'b1, 32'h11,  32'hFFFFFFFF, 2'd1, 1'b0, 0, 32'h0,        1'b1});
    tbl.push_back('{0, 1'b1, 32'd4096, 32'h11111111, 2'd2, 1'b0, 0, 32'h0,       1'b1});
    tbl.push_back('{0, 1'b1, 32'd4092, 32'hCAFEF00D, 2'd2, 1'b0, 0, 32'h0,       1'b0});
    tbl.push_back('{0, 1'b0, 32'd4092, 32'h0,       2'd2, 1'b0, 0, 32'hCAFEF00D, 1'b0});
    tbl.push_back('{0, 1'b0, 32'h10,  32'h0,        2'd2, 1'b0, 5, 32'hDEAD55EF, 1'b0});

    sel = 0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = '0; req_unsigned = 1'b0; resp_ready = 1'b0;

    // Reset state
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_rdy%0d", i), 32'(rdy[i]), 32'd0);
      chk($sformatf("rst_vld%0d", i), 32'(vld[i]), 32'd0);
      chk($sformatf("rst_err%0d", i), 32'(err[i]), 32'd0);
      chk($sformatf("rst_rdata%0d", i), rdata[i], 32'd0);
    end
    @(negedge clk) rst = 1'b0;
    #1 chk("post_rst_rdy", 32'(rdy[0]), 32'd1);

    // Directed table on the WAIT_CYCLES=1 instance
    for (int i = 0; i < tbl.size(); i++) begin
      model_access(tbl[i].inst, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].sz,
                   tbl[i].uns, dummy_rd, dummy_e);
      do_req(tbl[i].inst, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].sz, tbl[i].uns,
             tbl[i].hold, tbl[i].exp_rd, tbl[i].exp_err, $sformatf("tbl%0d", i));
    end

    // Reset while a response is being held
    start_req(0, 1'b0, 32'h0, 32'h0, 2'd3, 1'b0, ok);
    @(posedge clk); #1;
    chk("resp_rst_pre_vld", 32'(vld[0]), 32'd1);
    chk("resp_rst_pre_err", 32'(err[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("resp_rst_vld", 32'(vld[0]), 32'd0);
    chk("resp_rst_err", 32'(err[0]), 32'd0);
    chk("resp_rst_rdy", 32'(rdy[0]), 32'd0);
    #1 rst = 1'b0;

    // Reset mid-ACCESS on the WAIT_CYCLES=3 instance: store must not land
    model_req(1, 1'b1, 32'h20, 32'hA5A50001, 2'd2, 1'b0, 0, "w3_init");
    model_access(1, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, old_val, dummy_e);
    start_req(1, 1'b1, 32'h20, 32'h12345678, 2'd2, 1'b0, ok);
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    chk("acc_rst_vld", 32'(vld[1]), 32'd0);
    chk("acc_rst_err", 32'(err[1]), 32'd0);
    chk("acc_rst_rdata", rdata[1], 32'd0);
    chk("acc_rst_rdy", 32'(rdy[1]), 32'd0);
    #1 rst = 1'b0;
    do_req(1, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 0, old_val, 1'b0, "acc_rst_load");
    chk("acc_rst_old_val", old_val, 32'hA5A50001);

    // Fill random-test regions with known data
    for (int inst = 0; inst < 3; inst += 2) begin
      for (int a = 0; a < 64; a += 4)
        model_req(inst, 1'b1, 32'(a), $urandom, 2'd2, 1'b0, 0, "fill");
      for (int a = 4080; a < 4096; a += 4)
        model_req(inst, 1'b1, 32'(a), $urandom, 2'd2, 1'b0, 0, "fill_hi");
    end

    // Randomized traffic against the model
    for (int k = 0; k < 240; k++) begin
      int inst = (k % 2 == 0) ? 0 : 2;
      logic [1:0] sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      int r = $urandom_range(0, 19);
      logic [31:0] a;
      if (r < 16)      a = 32'($urandom_range(0, 63));
      else if (r < 19) a = 32'($urandom_range(4080, 4100));
      else             a = 32'hFFFF_FFFC;
      if ($urandom_range(0, 1) == 1 && sz != 2'd3)
        a = a & ~((32'd1 << sz) - 32'd1);
      model_req(inst, 1'($urandom_range(0, 1)), a, $urandom, sz, 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), $sformatf("rnd%0d", k));
    end

    // Back-to-back loads on WAIT_CYCLES=0 with resp_ready tied high
    b_addr[0] = 32'h0; b_addr[1] = 32'h4; b_addr[2] = 32'h8; b_addr[3] = 32'h3C;
    for (int i = 0; i < 4; i++)
      model_access(2, 1'b0, b_addr[i], 32'h0, 2'd2, 1'b0, b_exp[i], dummy_e);
    na = 0; nv = 0;
    @(negedge clk);
    sel = 2; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = b_addr[0]; req_valid = 1'b1; resp_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      bit was;
      if (cyc > 0) @(negedge clk);
      was = rdy[2] && req_valid;
      @(posedge clk); #1;
      if (vld[2]) begin
        if (nv < 4 && nv < na) begin
          chk($sformatf("b2b_lat%0d", nv), 32'(cyc), 32'(acc_cyc[nv] + 1));
          chk($sformatf("b2b_rdata%0d", nv), rdata[2], b_exp[nv]);
        end
        nv++;
      end
      if (was) begin
        if (na < 4) acc_cyc[na] = cyc;
        na++;
        if (na >= 4) req_valid = 1'b0;
        else         req_addr = b_addr[na];
      end
    end
    resp_ready = 1'b0;
    chk("b2b_accepts", 32'(na), 32'd4);
    chk("b2b_resps", 32'(nv), 32'd4);
    for (int i = 0; i < 3; i++)
      chk($sformatf("b2b_spacing%0d", i), 32'(acc_cyc[i+1] - acc_cyc[i]), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
